trng_sample_ctrl: RTL

TRNG_SAMPLE_CTRL -- requirements
Module: trng_sample_ctrl

---
 rtl/trng_sample_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/trng_sample_ctrl.sv
// -----------------------------------------------------------------------------
// trng_sample_ctrl
//
// Sampling controller for a true random number generator. It paces an
// external entropy source with a programmable divider and discards a warm-up
// run of samples after every start. It then assembles 8 samples MSB-first into
// a byte and holds that byte until the consumer reads it. A repetition-count
// health test runs on every sample, including warm-up samples. A run of
// RCT_LIMIT identical samples latches a sticky failure and parks the FSM in
// FAIL until the next start.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   ena          block enable; low aborts to IDLE (except from FAIL)
//   start        level-sampled request to begin generation
//   cont         1 = after a read, go straight back to COLLECT (no warm-up)
//   div [3:0]    sample divider; one sample tick every div+1 cycles
//   raw_bit      entropy source output, captured on a tick
//   rd           consumer read strobe for the held byte
//   sample_en    one-cycle pulse to the entropy source on each tick
//   byte_out     assembled random byte
//   valid        byte_out holds an unread byte
//   busy         high in WARMUP or COLLECT
//   health_fail  sticky repetition-count failure flag
// -----------------------------------------------------------------------------
module trng_sample_ctrl #(
    parameter int WARMUP_SAMPLES = 16,
    parameter int RCT_LIMIT      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       cont,
    input  logic [3:0] div,
    input  logic       raw_bit,
    input  logic       rd,
    output logic       sample_en,
    output logic [7:0] byte_out,
    output logic       valid,
    output logic       busy,
    output logic       health_fail
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WARMUP  = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;

    // The sample counter serves both warm-up (up to WARMUP_SAMPLES) and
    // byte assembly (up to 8), so it is at least 4 bits wide.
    localparam int SCW = ($clog2(WARMUP_SAMPLES + 1) > 4) ? $clog2(WARMUP_SAMPLES + 1) : 4;
    localparam logic [SCW-1:0] WARM_LAST = SCW'(WARMUP_SAMPLES - 1);
    localparam logic [SCW-1:0] BYTE_LAST = SCW'(7);
    localparam logic [3:0]     RCT_LIM   = 4'(RCT_LIMIT);

    // With no warm-up configured, a start goes directly to collection.
    localparam logic [2:0] S_FIRST = (WARMUP_SAMPLES == 0) ? S_COLLECT : S_WARMUP;

    logic [2:0]     r_state;
    logic [3:0]     r_div_cnt;
    logic [SCW-1:0] r_smp_cnt;
    logic [7:0]     r_sreg;
    logic [3:0]     r_rct;
    logic           r_last_bit;
    logic [7:0]     r_byte;
    logic           r_valid;
    logic           r_fail;

    logic           w_active;
    logic           w_tick;
    logic [3:0]     w_rct_next;
    logic           w_rct_trip;
    logic [7:0]     w_byte_next;

    assign w_active    = (r_state == S_WARMUP) || (r_state == S_COLLECT);
    assign w_tick      = w_active && (r_div_cnt == div);
    assign w_byte_next = {r_sreg[6:0], raw_bit};

    // Repetition count: zero marks "cleared", so the first sample after a
    // clear always starts a fresh run of length 1.
    always_comb begin
        // NOTE: give every combinational output a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_rct_next = 4'd1;
        if (r_rct != 4'd0 && raw_bit == r_last_bit) begin
            w_rct_next = (r_rct == 4'hF) ? 4'hF : r_rct + 4'd1;
        end
    end

    assign w_rct_trip = w_tick && (w_rct_next == RCT_LIM);

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: reset is sampled on the clock edge, so this block is the
            // only place state is forced; there is no asynchronous path.
            r_state    <= S_IDLE;
            r_div_cnt  <= 4'd0;
            r_smp_cnt  <= '0;
            r_sreg     <= 8'h00;
            r_rct      <= 4'd0;
            r_last_bit <= 1'b0;
            r_byte     <= 8'h00;
            r_valid    <= 1'b0;
            r_fail     <= 1'b0;
        end else if (!ena && r_state != S_FAIL) begin
            // Abort wins over a health failure or any normal transition.
            // FAIL is sticky and is left only through start.
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_div_cnt <= 4'd0;
            r_smp_cnt <= '0;
        end else begin
            // The divider free-runs only while sampling and restarts from 0
            // on every entry to WARMUP/COLLECT.
            if (w_active) begin
                r_div_cnt <= w_tick ? 4'd0 : r_div_cnt + 4'd1;
            end else begin
                r_div_cnt <= 4'd0;
            end

            if (w_tick) begin
                r_rct      <= w_rct_next;
                r_last_bit <= raw_bit;
            end

            if (w_rct_trip) begin
                // A failing sample overrides byte completion on the same tick.
                r_state   <= S_FAIL;
                r_fail    <= 1'b1;
                r_valid   <= 1'b0;
                r_sreg    <= 8'h00;
                r_smp_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state   <= S_FIRST;
                            r_smp_cnt <= '0;
                            r_sreg    <= 8'h00;
                            r_rct     <= 4'd0;
                        end
                    end
                    S_WARMUP: begin
                        if (w_tick) begin
                            if (r_smp_cnt == WARM_LAST) begin
                                r_state   <= S_COLLECT;
                                r_smp_cnt <= '0;
                            end else begin
                                r_smp_cnt <= r_smp_cnt + 1'b1;
                            end
                        end
                    end
                    S_COLLECT: begin
                        if (w_tick) begin
                            r_sreg <= w_byte_next;
                            if (r_smp_cnt == BYTE_LAST) begin
                                r_byte    <= w_byte_next;
                                r_valid   <= 1'b1;
                                r_state   <= S_HOLD;
                                r_smp_cnt <= '0;
                            end else begin
                                r_smp_cnt <= r_smp_cnt + 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        // The health counter is left untouched here, so a
                        // run can span bytes in continuous mode.
                        if (rd && r_valid) begin
                            r_valid <= 1'b0;
                            r_state <= cont ? S_COLLECT : S_IDLE;
                        end
                    end
                    S_FAIL: begin
                        if (start && ena) begin
                            r_state   <= S_FIRST;
                            r_fail    <= 1'b0;
                            r_smp_cnt <= '0;
                            r_sreg    <= 8'h00;
                            r_rct     <= 4'd0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sample_en   = w_tick;
    assign busy        = w_active;
    assign byte_out    = r_byte;
    assign valid       = r_valid;
    assign health_fail = r_fail;

endmodule
